// File: rtl/regfile_sequencer.sv
// Multicycle register-transfer sequencer driving the 8-entry register file.
// Accepts one request, reads operands, writes back, then pulses done.
module regfile_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [2:0]   req_rd,
  input  logic [2:0]   req_rs,
  input  logic [W-1:0] req_imm,
  input  logic [W-1:0] RD1,
  input  logic [W-1:0] RD2,
  output logic [2:0]   A_1,
  output logic [2:0]   A_2,
  output logic [2:0]   A_3,
  output logic [W-1:0] WD3,
  output logic         wen,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE1,
    S_WRITE2,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;
  localparam logic [2:0] PC_REG  = 3'd7;

  state_e       state_q, state_d;
  logic [2:0]   op_q, rd_q, rs_q;
  logic [W-1:0] imm_q, a_q, res_q, res_d;
  logic         bad_q, bad_d;
  logic         done_q, err_q;
  logic [W-1:0] result_q;
  logic         accept, wr_op, skip, swap2;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // R7 is the PC and is never a legal target
  assign wr_op = (req_op != OP_NOP) && (req_op != OP_RSV);
  assign bad_d = (req_op == OP_RSV)
              || (wr_op && req_rd == PC_REG)
              || (req_op == OP_SWAP && req_rs == PC_REG);

  assign skip  = bad_q || (op_q == OP_NOP);
  assign swap2 = (op_q == OP_SWAP) && (rd_q != rs_q);

  always_comb begin
    res_d = '0;
    case (op_q)
      OP_MOV:  res_d = RD2;
      OP_ADD:  res_d = RD1 + RD2;
      OP_SUB:  res_d = RD1 - RD2;
      OP_LDI:  res_d = imm_q;
      OP_SWAP: res_d = RD2;
      OP_INC:  res_d = RD1 + W'(1);
      default: res_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    A_1     = '0;
    A_2     = '0;
    A_3     = '0;
    WD3     = '0;
    wen     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_READ;
      end
      S_READ: begin
        A_1     = rd_q;
        A_2     = rs_q;
        state_d = skip ? S_DONE : S_WRITE1;
      end
      S_WRITE1: begin
        A_3     = rd_q;
        WD3     = res_q;
        wen     = 1'b1;
        state_d = swap2 ? S_WRITE2 : S_DONE;
      end
      S_WRITE2: begin
        A_3     = rs_q;
        WD3     = a_q;
        wen     = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // done/err/result are registered, so they trail the DONE state by a cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      imm_q    <= '0;
      bad_q    <= 1'b0;
      a_q      <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= req_op;
        rd_q  <= req_rd;
        rs_q  <= req_rs;
        imm_q <= req_imm;
        bad_q <= bad_d;
      end
      if (state_q == S_READ) begin
        a_q   <= RD1;
        res_q <= res_d;
      end
      done_q   <= (state_q == S_DONE);
      err_q    <= (state_q == S_DONE) && bad_q;
      result_q <= (state_q == S_DONE && !skip) ? res_q : '0;
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with a behavioural register file.
// Expected writes and completions are queued at acceptance time.
module tb_regfile_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op, req_rd, req_rs;
  logic [W-1:0] req_imm;
  logic [W-1:0] RD1, RD2;
  logic [2:0]   A_1, A_2, A_3;
  logic [W-1:0] WD3;
  logic         wen, done, err;
  logic [W-1:0] result;

  regfile_sequencer #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs),
    .req_imm(req_imm), .RD1(RD1), .RD2(RD2),
    .A_1(A_1), .A_2(A_2), .A_3(A_3), .WD3(WD3), .wen(wen),
    .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  logic [W-1:0] rf [8] = '{default: '0};
  logic [W-1:0] mdl [8] = '{default: '0};

  assign RD1 = rf[A_1];
  assign RD2 = rf[A_2];

  always @(posedge clk) begin
    if (wen) rf[A_3] <= WD3;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         err;
    logic [W-1:0] res;
    int           cyc;
  } dexp_t;

  dexp_t       dq[$];
  logic [10:0] wq[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wen) begin
      if (wq.size() == 0) chk("wen_unexp", 1, 0);
      else chk("wport", {A_3, WD3}, wq.pop_front());
    end else begin
      chk("wport_idle", {A_3, WD3}, 0);
    end
    if (done) begin
      if (dq.size() == 0) chk("done_unexp", 1, 0);
      else begin
        dexp_t d;
        d = dq.pop_front();
        chk("done_err", err, d.err);
        chk("done_res", result, d.res);
        chk("done_lat", cyc, d.cyc);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] rs, input logic [W-1:0] imm,
                      input bit hold, output int waits);
    logic [W-1:0] a, b, res;
    logic         e, nop, sw2;
    dexp_t        d;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd;
    req_rs    = rs;
    req_imm   = imm;
    waits     = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 1, 0);
      req_valid = 1'b0;
      return;
    end
    a   = mdl[rd];
    b   = mdl[rs];
    nop = (op == 3'b000);
    e   = (op == 3'b111) || (!nop && rd == 3'd7) ||
          (op == 3'b101 && rs == 3'd7);
    case (op)
      3'b001:  res = b;
      3'b010:  res = a + b;
      3'b011:  res = a - b;
      3'b100:  res = imm;
      3'b101:  res = b;
      3'b110:  res = a + 8'd1;
      default: res = '0;
    endcase
    sw2   = (op == 3'b101) && (rd != rs) && !e;
    d.err = e;
    d.res = (e || nop) ? '0 : res;
    d.cyc = cyc + 1 + ((e || nop) ? 2 : (sw2 ? 4 : 3));
    dq.push_back(d);
    if (!e && !nop) begin
      wq.push_back({rd, res});
      mdl[rd] = res;
      if (sw2) begin
        wq.push_back({rs, a});
        mdl[rs] = a;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (dq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (dq.size() != 0) begin
      chk("done_timeout", dq.size(), 0);
      dq.delete();
    end
  endtask

  int w;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_rd    = '0;
    req_rs    = '0;
    req_imm   = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {req_ready, A_1, A_2, A_3, WD3, wen, done, err, result}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    send(3'b100, 3'd2, 3'd0, 8'h5A, 0, w);
    wait_done();
    chk("r2_ldi", rf[2], 8'h5A);

    send(3'b100, 3'd0, 3'd0, 8'hF0, 0, w);
    send(3'b100, 3'd1, 3'd0, 8'h20, 0, w);
    send(3'b010, 3'd0, 3'd1, 8'h00, 0, w);
    wait_done();
    chk("r0_add", rf[0], 8'h10);
    chk("r1_keep", rf[1], 8'h20);

    send(3'b100, 3'd3, 3'd0, 8'h11, 0, w);
    send(3'b100, 3'd4, 3'd0, 8'h22, 0, w);
    send(3'b101, 3'd3, 3'd4, 8'h00, 0, w);
    send(3'b101, 3'd3, 3'd3, 8'h00, 0, w);
    wait_done();
    chk("r3_swap", rf[3], 8'h22);
    chk("r4_swap", rf[4], 8'h11);

    send(3'b001, 3'd7, 3'd1, 8'h00, 0, w);
    send(3'b111, 3'd1, 3'd1, 8'h00, 0, w);
    send(3'b101, 3'd1, 3'd7, 8'h00, 0, w);
    send(3'b000, 3'd7, 3'd7, 8'h00, 0, w);
    send(3'b011, 3'd4, 3'd3, 8'h00, 0, w);
    send(3'b001, 3'd6, 3'd4, 8'h00, 0, w);
    wait_done();

    send(3'b100, 3'd2, 3'd0, 8'hFF, 0, w);
    wait_done();
    send(3'b110, 3'd2, 3'd0, 8'h00, 1, w);
    send(3'b110, 3'd2, 3'd0, 8'h00, 0, w);
    chk("b2b_busy_cycles", w, 3);
    wait_done();
    chk("r2_inc", rf[2], 8'h01);

    send(3'b100, 3'd5, 3'd0, 8'h30, 0, w);
    send(3'b100, 3'd6, 3'd0, 8'h10, 0, w);
    wait_done();
    send(3'b011, 3'd5, 3'd6, 8'h00, 0, w);
    for (int i = 0; i < 10 && !wen; i++) @(negedge clk);
    chk("abort_in_write1", {wen, A_3}, {1'b1, 3'd5});
    reset = 1'b1;
    dq.delete();
    @(negedge clk);
    chk("abort_outs", {req_ready, A_1, A_2, A_3, WD3, wen, done, err, result}, 0);
    @(negedge clk);
    chk("abort_hold", {req_ready, wen, done}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", req_ready, 1);

    send(3'b001, 3'd6, 3'd2, 8'h00, 0, w);
    wait_done();
    repeat (3) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    for (int i = 0; i < 7; i++) chk("rf_final", rf[i], mdl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
